vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
// - Parametrised VGA/video timing generator. Next generation of the fixed 640x480 VGA controller.
// - Adds generic timing, selectable sync polarity and a pixel clock enable (clk_i may run faster than the pixel rate).
// - Adds run/stop control with a clean frame-boundary stop, and a pixel-request stream issued LEAD ticks ahead
//   of display, so pipelined sources (frame buffer, Sobel core) deliver data on time.
// - Sits between the pixel source and the DE2 VGA DAC pins.
// PARAMETERS
// - H_ACTIVE  640  active pixels per line
// - H_FRONT   16   horizontal front porch (ticks)
// - H_SYNC    96   hsync width (ticks)
// - H_BACK    48   horizontal back porch (ticks)
// - V_ACTIVE  480  active lines per frame
// - V_FRONT   10   vertical front porch (lines)
// - V_SYNC    2    vsync width (lines)
// - V_BACK    33   vertical back porch (lines)
// - SYNC_POL  0    0 = syncs active-low; 1 = syncs active-high
// - LEAD      2    ticks the request stream leads display; 0..H_BACK, checked by elaboration assertion
// - CW        11   counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
// - clk_i          in   1   system clock
// - rst_ni         in   1   reset, asynchronous, active-low
// - pix_ce_i       in   1   pixel tick; all timing advances only on clk_i edges with pix_ce_i=1
// - en_i           in   1   run request, level
// - busy_o         out  1   FSM not IDLE
// - req_o          out  1   request strobe: active pixel (req_x_o,req_y_o) is needed LEAD ticks from now
// - req_x_o        out  CW  request column
// - req_y_o        out  CW  request row
// - h_sync_o       out  1   horizontal sync, polarity per SYNC_POL
// - v_sync_o       out  1   vertical sync, polarity per SYNC_POL
// - video_en_o     out  1   display active (DAC blank_n)
// - pixel_x_o      out  CW  display column, aligned with video_en_o
// - pixel_y_o      out  CW  display row, aligned with video_en_o
// - line_start_o   out  1   one clk_i pulse when display enters column 0 of an active line
// - frame_start_o  out  1   one clk_i pulse when display enters (0,0)
// BEHAVIOUR
// - Totals: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL analogous.
// - Internal counters hc and vc (request timeline).
//   - hc wraps H_TOTAL-1 -> 0 and increments vc.
//   - vc wraps V_TOTAL-1 -> 0.
//   - Both update on ce ticks only.
// - Request stage, registered, one clk_i after the counter value:
//   - req_o = run & (hc < H_ACTIVE) & (vc < V_ACTIVE).
//   - req_x_o = hc, req_y_o = vc.
// - Display stage: {hsync, vsync, de, x, y} pass through a LEAD-deep shift pipe that advances on ce.
//   - Sync is asserted for hc in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1].
//   - The same rule applies to vc.
//   - When LEAD=0 the display stage equals the request stage.
// - FSM IDLE/RUN/DRAIN, evaluated on ce ticks:
//   - IDLE -> RUN when en_i=1. hc=vc=0 on the first RUN tick.
//   - RUN -> DRAIN when en_i=0.
//   - DRAIN -> RUN when en_i=1. Timing continues with no disruption.
//   - DRAIN -> IDLE on the tick with hc=H_TOTAL-1 and vc=V_TOTAL-1. The frame always completes.
//   - In IDLE, counters hold at 0 and a blank/inactive-sync sample is fed into the pipe. The pipe drains to blank within LEAD ticks.
// - Pulses (line_start_o, frame_start_o):
//   - Set on the ce tick where the display de rises at x=0 (and y=0 for frame_start_o).
//   - Cleared on the next clk_i edge. Width is one clk_i cycle, independent of the pix_ce_i rate.
// - pix_ce_i=0: all state and outputs hold, except that the pulses clear.
// - Reset values:
//   - FSM in IDLE, counters 0, pipe filled with blank.
//   - req_o, video_en_o, pulses and busy_o are 0. All coordinates are 0.
//   - Syncs are inactive (1 if SYNC_POL=0).
// - Reset asserted mid-frame: immediate return to the reset values. A new frame starts at (0,0) once en_i=1 after release.
// CONFIGURATION
// - Macro VGA_TEST_PATTERN_EN.
// - Defined: adds output tp_rgb_o [23:0].
//   - Eight vertical colour bars, each H_ACTIVE/8 wide, ordered white, yellow, cyan, green, magenta, red, blue, black.
//   - Channels are 8'hFF/8'h00, computed from pixel_x_o and registered in the display stage.
//   - tp_rgb_o = 0 when video_en_o=0.
// - Undefined: port and logic are absent, with no other change.
// TESTING
// - Reset with en_i=0, pix_ce_i=1: all outputs equal the reset values; h_sync_o=v_sync_o=1 and busy_o=0 for 1000 cycles.
// - Defaults, pix_ce_i=1, en_i=1:
//   - line period 800 cycles, frame period 420000 cycles;
//   - h_sync_o low for columns 656..751 and v_sync_o low for rows 490..491 of display timing;
//   - video_en_o high for 640 cycles per line.
// - LEAD=2: the req_o rise for (0,0) precedes the video_en_o rise by exactly 2 cycles. frame_start_o is a 1-cycle pulse coincident with that video_en_o rise.
// - pix_ce_i every 2nd cycle: all periods double (line 1600 cycles). frame_start_o is still exactly 1 clk_i wide.
// - en_i dropped at row 100: the frame completes; busy_o falls after the row-524/column-799 tick; video_en_o stays 0 afterwards.
// - rst_ni pulsed low mid-line: outputs return to reset values asynchronously; the next frame restarts at (0,0).
//   With VGA_TEST_PATTERN_EN, column 80 gives tp_rgb_o=24'hFFFF00.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator with run/stop control, a request stream
// that leads display by LEAD pixel ticks, and selectable sync polarity.
// Optional feature: define VGA_TEST_PATTERN_EN to add the tp_rgb_o colour-bar output.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned SYNC_POL = 0,
  parameter int unsigned LEAD     = 2,
  parameter int unsigned CW       = 11
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          pix_ce_i,
  input  logic          en_i,
  output logic          busy_o,
  output logic          req_o,
  output logic [CW-1:0] req_x_o,
  output logic [CW-1:0] req_y_o,
  output logic          h_sync_o,
  output logic          v_sync_o,
  output logic          video_en_o,
  output logic [CW-1:0] pixel_x_o,
  output logic [CW-1:0] pixel_y_o,
  output logic          line_start_o,
`ifdef VGA_TEST_PATTERN_EN
  output logic          frame_start_o,
  output logic [23:0]   tp_rgb_o
`else
  output logic          frame_start_o
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_LAST_C = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST_C = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HS_BEG_C = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS_END_C = CW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG_C = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS_END_C = CW'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  localparam logic SYNC_ON  = 1'(SYNC_POL != 0);
  localparam logic SYNC_OFF = 1'(SYNC_POL == 0);

  // Sample layout: {hsync, vsync, de, x, y}
  localparam int unsigned PW   = 3 + 2 * CW;
  localparam int unsigned DE_B = 2 * CW;
  localparam int unsigned VS_B = 2 * CW + 1;
  localparam int unsigned HS_B = 2 * CW + 2;
  localparam logic [PW-1:0] BLANK = {SYNC_OFF, SYNC_OFF, 1'b0, {(2 * CW){1'b0}}};

  // Parameter sanity, caught at elaboration
  if (LEAD > H_BACK) begin : g_bad_lead
    $error("vga_timing_gen: LEAD must be within 0..H_BACK");
  end
  if ((((H_TOTAL - 1) >> CW) != 0) || (((V_TOTAL - 1) >> CW) != 0)) begin : g_bad_cw
    $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] hc_q, hc_d;
  logic [CW-1:0] vc_q, vc_d;
  logic          busy_q, busy_d;
  logic          run;
  logic          last_pix;
  logic [PW-1:0] req_samp;

  logic [LEAD:0][PW-1:0] stage_q, stage_d;
  logic [PW-1:0]         disp_q, disp_d;
  logic                  line_start_q, frame_start_q;

  assign run      = (state_q != ST_IDLE);
  assign last_pix = (hc_q == H_LAST_C) && (vc_q == V_LAST_C);

  // Next-state and counter advance; everything moves only on pixel ticks
  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    vc_d    = vc_q;
    if (pix_ce_i) begin
      unique case (state_q)
        ST_IDLE:  if (en_i) state_d = ST_RUN;
        ST_RUN:   if (!en_i) state_d = ST_DRAIN;
        ST_DRAIN: begin
          if (en_i)          state_d = ST_RUN;
          else if (last_pix) state_d = ST_IDLE;
        end
        default:  state_d = ST_IDLE;
      endcase
      if (run) begin
        if (hc_q == H_LAST_C) begin
          hc_d = '0;
          vc_d = (vc_q == V_LAST_C) ? '0 : vc_q + CW'(1);
        end else begin
          hc_d = hc_q + CW'(1);
        end
      end
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      hc_q    <= '0;
      vc_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      busy_q  <= busy_d;
    end
  end

  // Request-timeline sample built from the current counters; blank while idle
  always_comb begin
    req_samp         = BLANK;
    req_samp[CW-1:0] = vc_q;
    req_samp[DE_B-1:CW] = hc_q;
    if (run) begin
      req_samp[DE_B] = (hc_q < H_ACT_C) && (vc_q < V_ACT_C);
      req_samp[HS_B] = ((hc_q >= HS_BEG_C) && (hc_q <= HS_END_C)) ? SYNC_ON : SYNC_OFF;
      req_samp[VS_B] = ((vc_q >= VS_BEG_C) && (vc_q <= VS_END_C)) ? SYNC_ON : SYNC_OFF;
    end
  end

  // Stage 0 is the request stage, stage LEAD is the display stage
  if (LEAD == 0) begin : g_no_pipe
    assign stage_d = req_samp;
  end else begin : g_pipe
    assign stage_d = {stage_q[LEAD-1:0], req_samp};
  end

  assign disp_q = stage_q[LEAD];
  assign disp_d = stage_d[LEAD];

  // Request/display shift pipe, advanced on pixel ticks
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= {(LEAD + 1){BLANK}};
    end else if (pix_ce_i) begin
      stage_q <= stage_d;
    end
  end

  // One-clock pulses on the tick where display enters column 0 of an active line
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= pix_ce_i && disp_d[DE_B] && !disp_q[DE_B]
                       && (disp_d[DE_B-1:CW] == '0);
      frame_start_q <= pix_ce_i && disp_d[DE_B] && !disp_q[DE_B]
                       && (disp_d[DE_B-1:CW] == '0) && (disp_d[CW-1:0] == '0);
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [CW-1:0] BAR_W_C = CW'(H_ACTIVE / 8);

  logic [CW-1:0] bar_q;
  logic [2:0]    bar;
  logic [23:0]   tp_d, tp_q;

  // Colour-bar lookup: white, yellow, cyan, green, magenta, red, blue, black
  always_comb begin
    bar_q = disp_d[DE_B-1:CW] / BAR_W_C;
    bar   = (bar_q > CW'(7)) ? 3'd7 : bar_q[2:0];
    tp_d  = '0;
    if (disp_d[DE_B]) begin
      tp_d = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
    end
  end

  // Test pattern registered alongside the display stage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tp_q <= '0;
    end else if (pix_ce_i) begin
      tp_q <= tp_d;
    end
  end

  assign tp_rgb_o = tp_q;
`endif

  assign busy_o        = busy_q;
  assign req_o         = stage_q[0][DE_B];
  assign req_x_o       = stage_q[0][DE_B-1:CW];
  assign req_y_o       = stage_q[0][CW-1:0];
  assign h_sync_o      = disp_q[HS_B];
  assign v_sync_o      = disp_q[VS_B];
  assign video_en_o    = disp_q[DE_B];
  assign pixel_x_o     = disp_q[DE_B-1:CW];
  assign pixel_y_o     = disp_q[CW-1:0];
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;

endmodule
